// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [2:0] {IDLE, CPU_A, CPU_D, EXT_A, EXT_D} arb_state_t;
  localparam logic [2:0] MODE_WORD = 3'b010;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating counter with synchronous clear
// Ports: clk, rst (async active-low), inc_i (count up), clr_i (clear, wins over inc_i),
//        cnt_o (current count, saturates at MAX)
module arb_starve_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU M-stage and an external requester
// Ports: clk, rst (async active-low); cpu_* request/response and stall; ext_* request/response
//        and grant; mem_* drive to data_memory, mem_rdata back from it.
// Build option: define DMEM_ARB_STARVE_GUARD_EN to force an external grant after
//        STARVE_LIMIT consecutive CPU grants while ext_req is pending.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic [2:0]       cpu_mode,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_done,
  output logic             stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [WIDTH-1:0] ext_addr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic             ext_gnt,
  output logic [WIDTH-1:0] ext_rdata,
  output logic             ext_done,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [2:0]       mem_mode,
  input  logic [WIDTH-1:0] mem_rdata
);
  arb_state_t       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             force_ext;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  logic          grant_cpu, grant_ext;
  assign force_ext = ext_req && starve_cnt == CW'(STARVE_LIMIT);
  assign grant_cpu = state_q == IDLE && cpu_req && !force_ext;
  assign grant_ext = state_q == IDLE && ext_req && (force_ext || !cpu_req);
  // Count only CPU wins that actually kept a pending external request waiting.
  arb_starve_counter #(.W(CW), .MAX(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (grant_cpu && ext_req),
    .clr_i (grant_ext || !ext_req),
    .cnt_o (starve_cnt)
  );
`else
  assign force_ext = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mode  = '0;
    cpu_done  = 1'b0;
    cpu_rdata = '0;
    ext_gnt   = 1'b0;
    ext_done  = 1'b0;
    ext_rdata = '0;
    case (state_q)
      IDLE:  state_d = (cpu_req && !force_ext) ? CPU_A : ext_req ? EXT_A : IDLE;
      CPU_A: begin
        state_d   = CPU_D;
        hold_d    = mem_rdata;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_mode  = cpu_mode;
      end
      CPU_D: begin
        state_d   = IDLE;
        cpu_done  = 1'b1;
        cpu_rdata = hold_q;
      end
      EXT_A: begin
        state_d   = EXT_D;
        hold_d    = mem_rdata;
        ext_gnt   = 1'b1;
        mem_we    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_mode  = MODE_WORD;
      end
      EXT_D: begin
        state_d   = IDLE;
        ext_done  = 1'b1;
        ext_rdata = hold_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = cpu_req & ~cpu_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter against a word-array reference memory
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [2:0]  cpu_mode = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done, stall;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [31:0] ext_addr = '0, ext_wdata = '0;
  logic        ext_gnt, ext_done;
  logic [31:0] ext_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_mode;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(32), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mode(cpu_mode), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .stall(stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk)
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  assign mem_rdata = mem[mem_addr[9:2]];

  int compared = 0, mismatched = 0;
  typedef struct packed {logic ld; logic [31:0] d;} exp_t;
  exp_t cpu_q[$], ext_q[$];
  exp_t ce, ee;
  logic        cpu_fixed = 1'b0;
  logic [31:0] fixed_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  always @(negedge clk) if (rst) begin
    if (cpu_done) begin
      if (cpu_fixed) chk("cpu_rdata_fixed", cpu_rdata, fixed_val);
      else if (cpu_q.size() == 0) fail("cpu_done_unexpected");
      else begin
        ce = cpu_q.pop_front();
        if (ce.ld) chk("cpu_rdata", cpu_rdata, ce.d);
      end
    end
    if (ext_done) begin
      if (ext_q.size() == 0) fail("ext_done_unexpected");
      else begin
        ee = ext_q.pop_front();
        if (ee.ld) chk("ext_rdata", ext_rdata, ee.d);
      end
    end
    if (ext_gnt) begin
      chk("ext_mode", 32'(mem_mode), 32'h2);
      chk("ext_addr", mem_addr, ext_addr);
    end
    chk("stall_def", 32'(stall), 32'(cpu_req & ~cpu_done));
  end

  task automatic push_cpu(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.ld = !we;
    e.d  = ref_mem[addr[9:2]];
    if (we) ref_mem[addr[9:2]] = wdata;
    cpu_q.push_back(e);
  endtask

  task automatic push_ext(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.ld = !we;
    e.d  = ref_mem[addr[9:2]];
    if (we) ref_mem[addr[9:2]] = wdata;
    ext_q.push_back(e);
  endtask

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] mode);
    int n;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_mode = mode;
    push_cpu(we, addr, wdata);
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_done && n < 40);
    if (!cpu_done) fail("cpu_timeout");
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic ext_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(posedge clk); #1;
    ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    push_ext(we, addr, wdata);
    n = 0;
    do begin @(negedge clk); n++; end while (!ext_done && n < 60);
    if (!ext_done) fail("ext_timeout");
    @(posedge clk); #1;
    ext_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncpu, n;
    logic seen;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      bd_we = 1'b1; bd_idx = 8'(i); bd_data = ref_mem[i];
    end
    @(posedge clk); #1;
    bd_we = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_cpu_done", 32'(cpu_done), 0);
    chk("rst_ext_done", 32'(ext_done), 0);
    chk("rst_ext_gnt", 32'(ext_gnt), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ext_rdata", ext_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_mode", 32'(mem_mode), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // CPU load timing
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_mode = 3'b010;
    push_cpu(1'b0, 32'h10, 0);
    @(negedge clk);
    chk("ld_stall_c0", 32'(stall), 1);
    chk("ld_done_c0", 32'(cpu_done), 0);
    @(negedge clk);
    chk("ld_stall_c1", 32'(stall), 1);
    chk("ld_addr_c1", mem_addr, 32'h10);
    @(negedge clk);
    chk("ld_done_c2", 32'(cpu_done), 1);
    chk("ld_rdata_c2", cpu_rdata, 32'hDEADBEEF);
    chk("ld_stall_c2", 32'(stall), 0);
    chk("ld_addr_c2", mem_addr, 0);
    chk("ld_mode_c2", 32'(mem_mode), 0);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // CPU store timing, then readback
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678; cpu_mode = 3'b010;
    push_cpu(1'b1, 32'h20, 32'h12345678);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("st_mem_we", 32'(mem_we), 32'(c == 1));
      if (c == 1) chk("st_wdata", mem_wdata, 32'h12345678);
      chk("st_done", 32'(cpu_done), 32'(c == 2));
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_op(1'b0, 32'h20, 0, 3'b010);

    // Simultaneous requests: CPU first, external right after
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; cpu_mode = 3'b010;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h80;
    push_cpu(1'b0, 32'h30, 0);
    push_ext(1'b0, 32'h80, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("sim_cpu_done", 32'(cpu_done), 32'(c == 2));
      chk("sim_ext_gnt", 32'(ext_gnt), 32'(c == 4));
      chk("sim_ext_done", 32'(ext_done), 32'(c == 5));
      @(posedge clk); #1;
      if (c == 2) cpu_req = 1'b0;
      if (c == 5) ext_req = 1'b0;
    end

    // External write with CPU idle
    @(posedge clk); #1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'hCAFEF00D;
    push_ext(1'b1, 32'h40, 32'hCAFEF00D);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ew_gnt", 32'(ext_gnt), 32'(c == 1));
      chk("ew_mem_we", 32'(mem_we), 32'(c == 1));
      if (c == 1) chk("ew_wdata", mem_wdata, 32'hCAFEF00D);
      chk("ew_done", 32'(ext_done), 32'(c == 2));
      chk("ew_stall", 32'(stall), 0);
      @(posedge clk); #1;
      if (c == 2) ext_req = 1'b0;
    end
    ext_op(1'b0, 32'h40, 0);

    // Starvation with both requests held
    fixed_val = ref_mem[12];
    cpu_fixed = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; cpu_mode = 3'b010;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h84;
    push_ext(1'b0, 32'h84, 0);
    ncpu = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (cpu_done) ncpu++;
      if (ext_gnt) begin seen = 1'b1; break; end
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    chk("starve_ext_gnt", 32'(seen), 1);
    chk("starve_cpu_count", 32'(ncpu), 2);
`else
    chk("starve_no_ext_gnt", 32'(seen), 0);
`endif
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ext_done && n < 40);
    if (!ext_done) fail("starve_ext_timeout");
    @(posedge clk); #1;
    ext_req = 1'b0;
    cpu_fixed = 1'b0;

    // Reset during CPU_A
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h5555AAAA; cpu_mode = 3'b010;
    @(posedge clk); #1;
    chk("ra_mem_we_before", 32'(mem_we), 1);
    rst = 1'b0;
    #1;
    chk("ra_mem_we", 32'(mem_we), 0);
    chk("ra_mem_addr", mem_addr, 0);
    chk("ra_mem_wdata", mem_wdata, 0);
    chk("ra_mem_mode", 32'(mem_mode), 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ra_no_done", 32'(cpu_done), 0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; cpu_mode = 3'b010;
    push_cpu(1'b0, 32'h44, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ra_reload_done", 32'(cpu_done), 32'(c == 2));
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // Random concurrent traffic in disjoint regions
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        cpu_op(1'($urandom_range(0, 1)), {22'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
               3'($urandom_range(0, 7)));
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        ext_op(1'($urandom_range(0, 1)), {22'd0, 2'b01, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
      end
    join
    repeat (5) @(posedge clk);
    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    chk("ext_q_drained", 32'(ext_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
